// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache.
// CPU side answers hits combinationally (zero-cycle latency); misses fill and
// evict whole 128-bit lines over the physical-memory port. The pmem outputs
// are registered from the FSM; only mem_resp and mem_rdata are combinational.
module l1_dcache #(
    parameter int NUM_SETS  = 8,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [1:0]           mem_byte_enable,
    input  logic [15:0]          mem_address,
    input  logic [15:0]          mem_wdata,
    output logic [15:0]          mem_rdata,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [15:0]          pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 16 - 4 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t               state;
    logic [NUM_SETS-1:0]  valid;
    logic [NUM_SETS-1:0]  dirty;
    logic [TAG_W-1:0]     tags [NUM_SETS];
    logic [LINE_BITS-1:0] data [NUM_SETS];

    // Miss target latched at miss time so the fill completes even if the
    // requester drops its request mid-transaction.
    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_idx;

    logic [IDX_W-1:0]     addr_idx;
    logic [TAG_W-1:0]     addr_tag;
    logic [2:0]           word_sel;
    logic                 request;
    logic                 hit;
    logic [LINE_BITS-1:0] cur_line;
    logic [LINE_BITS-1:0] merged_line;
    logic                 unused_addr_bit;

    assign addr_idx        = mem_address[4 +: IDX_W];
    assign addr_tag        = mem_address[15 -: TAG_W];
    assign word_sel        = mem_address[3:1];
    assign unused_addr_bit = mem_address[0];

    assign request   = mem_read | mem_write;
    assign cur_line  = data[addr_idx];
    assign hit       = (state == IDLE) && request && valid[addr_idx] &&
                       (tags[addr_idx] == addr_tag);
    assign mem_resp  = hit;
    assign mem_rdata = cur_line[{word_sel, 4'b0000} +: 16];

    // Byte-masked merge of the write data into the currently indexed line.
    always_comb begin
        merged_line = cur_line;
        if (mem_byte_enable[0]) merged_line[{word_sel, 4'b0000} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged_line[{word_sel, 4'b1000} +: 8] = mem_wdata[15:8];
    end

    // Controller FSM: valid/dirty bookkeeping and registered pmem outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            valid        <= '0;
            dirty        <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            req_tag      <= '0;
            req_idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit && mem_write) begin
                        dirty[addr_idx] <= 1'b1;
                    end else if (request && !hit) begin
                        req_tag <= addr_tag;
                        req_idx <= addr_idx;
                        if (valid[addr_idx] && dirty[addr_idx]) begin
                            state        <= WRITEBACK;
                            pmem_write   <= 1'b1;
                            pmem_address <= {tags[addr_idx], addr_idx, 4'b0000};
                            pmem_wdata   <= cur_line;
                        end else begin
                            state        <= FILL;
                            pmem_read    <= 1'b1;
                            pmem_address <= {addr_tag, addr_idx, 4'b0000};
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state        <= FILL;
                        pmem_write   <= 1'b0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, req_idx, 4'b0000};
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        state          <= IDLE;
                        pmem_read      <= 1'b0;
                        pmem_address   <= '0;
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays: write-hit merge and line install; never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (hit && mem_write) begin
                data[addr_idx] <= merged_line;
            end else if (state == FILL && pmem_resp) begin
                data[req_idx] <= pmem_rdata;
                tags[req_idx] <= req_tag;
            end
        end
    end

    // Simultaneous read and write is illegal; the write wins in the logic above.
    rw_exclusive: assert property (@(posedge clk) disable iff (reset)
                                   !(mem_read && mem_write));

endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: scoreboard bench for l1_dcache with a behavioural pmem model
// that has programmable writeback/fill response delays.
module tb_l1_dcache;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_read, mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address, mem_wdata, mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    // Backing store and the bench's architectural view of memory.
    logic [127:0] mem_line [4096];
    logic [15:0]  ref_word [32768];

    logic [15:0]  exp_q[$];
    bit           log_wr[$];
    logic [15:0]  log_addr[$];
    logic [127:0] log_data[$];

    int tw = 1;
    int tf = 1;
    int unstable = 0;
    int resp_during_pmem = 0;

    l1_dcache dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    // Physical memory: responds after tw/tf cycles of a held request and
    // watches that the request stays stable while it waits.
    initial begin
        int           cnt;
        bit           busy;
        bit           t_wr;
        logic [15:0]  t_addr;
        logic [127:0] t_wdata;
        cnt = 0; busy = 0; t_wr = 0; t_addr = '0; t_wdata = '0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (mem_resp && (pmem_read || pmem_write)) resp_during_pmem++;
            if (reset || !(pmem_read || pmem_write)) begin
                busy = 0;
                cnt = 0;
            end else begin
                if (!busy) begin
                    busy = 1; cnt = 0;
                    t_wr = pmem_write; t_addr = pmem_address; t_wdata = pmem_wdata;
                end else if (pmem_address !== t_addr || pmem_write !== t_wr ||
                             (t_wr && pmem_wdata !== t_wdata)) begin
                    unstable++;
                end
                cnt++;
                if (cnt >= (t_wr ? tw : tf)) begin
                    pmem_resp = 1'b1;
                    busy = 0;
                    log_wr.push_back(t_wr);
                    log_addr.push_back(pmem_address);
                    log_data.push_back(pmem_wdata);
                    if (t_wr) mem_line[pmem_address[15:4]] = pmem_wdata;
                    else      pmem_rdata = mem_line[pmem_address[15:4]];
                end
            end
        end
    end

    function automatic logic [127:0] ref_line(input int l);
        logic [127:0] v;
        for (int w = 0; w < 8; w++) v[16*w +: 16] = ref_word[l*8 + w];
        return v;
    endfunction

    task automatic clear_logs();
        log_wr.delete(); log_addr.delete(); log_data.delete();
    endtask

    // Issue one CPU request (caller is just past a rising edge), wait for
    // mem_resp, compare read data against the scoreboard, then release.
    task automatic do_req(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [1:0] be, output int lat);
        logic [15:0] exp;
        bit done;
        mem_read = !wr; mem_write = wr;
        mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
        if (!wr) exp_q.push_back(ref_word[addr[15:1]]);
        else begin
            if (be[0]) ref_word[addr[15:1]][7:0]  = wd[7:0];
            if (be[1]) ref_word[addr[15:1]][15:8] = wd[15:8];
        end
        lat = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (mem_resp) done = 1;
            else begin
                lat++;
                if (lat > 200) begin
                    checks++; errors++;
                    $display("FAIL resp_timeout addr=%h got no mem_resp want mem_resp within 200 cycles", addr);
                    done = 1;
                end
            end
        end
        if (!wr && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            if (mem_resp) begin
                checks++;
                if (mem_rdata !== exp) begin
                    errors++;
                    $display("FAIL rdata addr=%h got %h want %h", addr, mem_rdata, exp);
                end
            end
        end
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_resp !== 1'b0)    begin errors++; $display("FAIL rst_mem_resp got %b want 0", mem_resp); end
        checks++; if (pmem_read !== 1'b0)   begin errors++; $display("FAIL rst_pmem_read got %b want 0", pmem_read); end
        checks++; if (pmem_write !== 1'b0)  begin errors++; $display("FAIL rst_pmem_write got %b want 0", pmem_write); end
        checks++; if (pmem_address !== 16'h0) begin errors++; $display("FAIL rst_pmem_address got %h want 0", pmem_address); end
        checks++; if (dut.valid !== 8'h00)  begin errors++; $display("FAIL rst_valid got %h want 00", dut.valid); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss();
        int lat;
        tf = 2; clear_logs();
        do_req(0, 16'h0000, 16'h0, 2'b00, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL miss_lat got %0d want 3", lat); end
        checks++;
        if (log_wr.size() != 1 || log_wr[0] != 0 || log_addr[0] !== 16'h0000) begin
            errors++; $display("FAIL miss_pmem txns=%0d want one read at 0000", log_wr.size());
        end
        do_req(0, 16'h000E, 16'h0, 2'b00, lat);
        checks++; if (lat != 0) begin errors++; $display("FAIL hit_lat got %0d want 0", lat); end
    endtask

    task automatic test_write_hit();
        int lat;
        do_req(1, 16'h0004, 16'hBEEF, 2'b01, lat);
        checks++; if (lat != 0) begin errors++; $display("FAIL wr_hit_lat got %0d want 0", lat); end
        do_req(0, 16'h0004, 16'h0, 2'b00, lat);
        checks++; if (dut.dirty[0] !== 1'b1) begin errors++; $display("FAIL wr_dirty got %b want 1", dut.dirty[0]); end
        do_req(1, 16'h0006, 16'hFFFF, 2'b00, lat);
        checks++; if (lat != 0) begin errors++; $display("FAIL wr_mask0_lat got %0d want 0", lat); end
        do_req(0, 16'h0006, 16'h0, 2'b00, lat);
        do_req(1, 16'h0008, 16'hA5C3, 2'b10, lat);
        do_req(0, 16'h0008, 16'h0, 2'b00, lat);
    endtask

    task automatic test_dirty_conflict();
        int lat;
        logic [127:0] exp_line;
        tw = 3; tf = 2; clear_logs();
        exp_line = ref_line(0);
        do_req(0, 16'h0080, 16'h0, 2'b00, lat);
        checks++; if (lat != 6) begin errors++; $display("FAIL wb_lat got %0d want 6", lat); end
        checks++;
        if (log_wr.size() != 2 || log_wr[0] != 1 || log_addr[0] !== 16'h0000 || log_data[0] !== exp_line) begin
            errors++; $display("FAIL wb_txn txns=%0d want writeback of modified line at 0000", log_wr.size());
        end
        checks++;
        if (log_wr.size() != 2 || log_wr[1] != 0 || log_addr[1] !== 16'h0080) begin
            errors++; $display("FAIL wb_fill_txn txns=%0d want fill at 0080 after writeback", log_wr.size());
        end
    endtask

    task automatic test_clean_conflict();
        int lat;
        tf = 2; clear_logs();
        do_req(0, 16'h0100, 16'h0, 2'b00, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL clean_lat got %0d want 3", lat); end
        checks++;
        if (log_wr.size() != 1 || log_wr[0] != 0 || log_addr[0] !== 16'h0100) begin
            errors++; $display("FAIL clean_txn txns=%0d want single read at 0100", log_wr.size());
        end
        do_req(0, 16'h000E, 16'h0, 2'b00, lat);
        do_req(0, 16'h000E, 16'h0, 2'b00, lat);
        checks++; if (lat != 0) begin errors++; $display("FAIL refill_hit_lat got %0d want 0", lat); end
    endtask

    task automatic test_reset_in_fill();
        int lat;
        tf = 50;
        mem_read = 1; mem_address = 16'h0180;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL fill_active got %b want 1", pmem_read); end
        reset = 1'b1; mem_read = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL abort_pmem_read got %b want 0", pmem_read); end
        checks++; if (dut.valid !== 8'h00) begin errors++; $display("FAIL abort_valid got %h want 00", dut.valid); end
        tf = 2; clear_logs();
        do_req(0, 16'h000E, 16'h0, 2'b00, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL post_rst_miss_lat got %0d want 3", lat); end
        checks++;
        if (log_wr.size() != 1 || log_addr[0] !== 16'h0000) begin
            errors++; $display("FAIL post_rst_txn txns=%0d want one fill at 0000", log_wr.size());
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [127:0] exp_line;
        tw = 5; tf = 5;
        do_req(1, 16'h000E, 16'h1234, 2'b11, lat);
        exp_line = ref_line(0);
        unstable = 0; clear_logs();
        do_req(0, 16'h0080, 16'h0, 2'b00, lat);
        checks++; if (lat != 11) begin errors++; $display("FAIL stall_lat got %0d want 11", lat); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", unstable); end
        checks++;
        if (log_wr.size() != 2 || log_data[0] !== exp_line || log_addr[1] !== 16'h0080) begin
            errors++; $display("FAIL stall_txn txns=%0d want wb of modified line then fill 0080", log_wr.size());
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int lat_sum;
        tf = 1;
        do_req(0, 16'h0010, 16'h0, 2'b00, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL b2b_miss_lat got %0d want 2", lat); end
        lat_sum = 0;
        do_req(1, 16'h0012, 16'h55AA, 2'b11, lat); lat_sum += lat;
        do_req(0, 16'h0012, 16'h0, 2'b00, lat);    lat_sum += lat;
        do_req(0, 16'h001E, 16'h0, 2'b00, lat);    lat_sum += lat;
        do_req(0, 16'h0080, 16'h0, 2'b00, lat);    lat_sum += lat;
        checks++; if (lat_sum != 0) begin errors++; $display("FAIL b2b_hit_lat got %0d want 0", lat_sum); end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ref_word[i] = 16'(((i >> 3) << 4) | (i & 7));
        for (int l = 0; l < 4096; l++)
            for (int w = 0; w < 8; w++) mem_line[l][16*w +: 16] = 16'(l * 16 + w);
        reset = 1'b1; mem_read = 0; mem_write = 0;
        mem_byte_enable = 2'b00; mem_address = '0; mem_wdata = '0;

        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_conflict();
        test_clean_conflict();
        test_reset_in_fill();
        test_stall();
        test_back_to_back();

        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
        checks++; if (resp_during_pmem != 0) begin errors++; $display("FAIL resp_in_pmem got %0d want 0", resp_during_pmem); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
